// File: rtl/key_conditioner.sv
// key_conditioner: debounce an active-low push-button into press/release/held/auto-repeat signals; auto-repeat is built only when KEY_CONDITIONER_AUTOREPEAT_EN is defined
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic key_n_i,
  output logic pressed_o,
  output logic released_o,
  output logic held_o,
  output logic repeat_o
);
  localparam int MAXP = DEBOUNCE_CYCLES > REPEAT_DELAY ?
                        (DEBOUNCE_CYCLES > REPEAT_PERIOD ? DEBOUNCE_CYCLES : REPEAT_PERIOD) :
                        (REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam int W = $clog2(MAXP) + 1;
  localparam logic [W-1:0] DEB_LAST = W'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_t;
  state_t         state_q;
  logic           s1_q, ks_q;
  logic [W-1:0]   cnt_q;
  logic           pressed_q, released_q, held_q;
  logic           press_accept;
  assign press_accept = state_q == DEB_PRESS && !ks_q && cnt_q == DEB_LAST;
  assign pressed_o  = pressed_q;
  assign released_o = released_q;
  assign held_o     = held_q;
  // synchronizer, debounce FSM and its registered pulse/level outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q       <= 1'b1;
      ks_q       <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      s1_q       <= key_n_i;
      ks_q       <= s1_q;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      held_q     <= state_q == HELD || state_q == DEB_RELEASE;
      case (state_q)
        IDLE: begin
          if (!ks_q) begin
            state_q <= DEB_PRESS;
            cnt_q   <= '0;
          end
        end
        DEB_PRESS: begin
          if (ks_q) state_q <= IDLE;
          else if (cnt_q == DEB_LAST) begin
            state_q   <= HELD;
            pressed_q <= 1'b1;
          end else cnt_q <= cnt_q + W'(1);
        end
        HELD: begin
          if (ks_q) begin
            state_q <= DEB_RELEASE;
            cnt_q   <= '0;
          end
        end
        DEB_RELEASE: begin
          if (!ks_q) state_q <= HELD;
          else if (cnt_q == DEB_LAST) begin
            state_q    <= IDLE;
            released_q <= 1'b1;
          end else cnt_q <= cnt_q + W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
  logic [W-1:0] rcnt_q;
  logic         repeat_q;
  assign repeat_o = repeat_q;
  // repeat timer keeps absolute time through release bounces so a masked instant is dropped, not delayed
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rcnt_q   <= '0;
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= 1'b0;
      if (press_accept) rcnt_q <= W'(REPEAT_DELAY - 1);
      else if (state_q == HELD || state_q == DEB_RELEASE) begin
        rcnt_q   <= rcnt_q == '0 ? W'(REPEAT_PERIOD - 1) : rcnt_q - W'(1);
        repeat_q <= rcnt_q == '0 && state_q == HELD && !ks_q;
      end
    end
  end
`else
  logic unused_press_accept;
  assign unused_press_accept = press_accept;
  assign repeat_o = 1'b0;
`endif
endmodule
